// File: rtl/uart2apb_rsp_pkg.sv
// Shared definitions for the UART-to-APB response framer.
// Holds the state encoding, STATUS bit positions, the default frame header,
// the nominal frame lengths, the captured-response record and two small
// byte-building helpers used by uart2apb_rsp_packer.
package uart2apb_rsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_STAT = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam int ERR_BIT = 0;
    localparam int WR_BIT  = 1;

    localparam logic [7:0] DEF_HDR = 8'h5A;

    // Frame lengths without the optional trailing checksum byte.
    localparam int READ_LEN  = 6;
    localparam int WRITE_LEN = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        is_wr;
        logic        err;
    } rsp_t;

    function automatic logic [7:0] status_byte(input logic is_wr, input logic err);
        logic [7:0] s;
        s         = 8'h00;
        s[WR_BIT]  = is_wr;
        s[ERR_BIT] = err;
        return s;
    endfunction

    // Data byte for payload slot idx; MSB-first order walks the lanes backwards.
    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] idx,
                                             input logic lsb_first);
        logic [1:0] lane;
        logic [7:0] b;
        lane = lsb_first ? idx : ~idx;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart2apb_rsp_packer.sv
// uart2apb_rsp_packer: frames one APB transaction result into bytes for the
// TX byte FIFO.
//   Read frame : HDR, STATUS, D0..D3     Write frame : HDR, STATUS
//   STATUS = {6'b0, is_wr, err}
// Optional macro UART2APB_RSP_CHECKSUM_EN appends an XOR checksum byte covering
// every preceding byte of the frame (HDR included).
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   rsp_valid/rsp_ready           response handshake (ready only when idle)
//   rsp_data, rsp_is_wr, rsp_err  response payload, captured on acceptance
//   wr_data/wr_req/wr_ready       byte FIFO write handshake (registered outputs)
//   busy                          a frame is in progress
//   frame_cnt                     completed frame count, wraps at 16 bits
module uart2apb_rsp_packer
    import uart2apb_rsp_pkg::*;
#(
    parameter logic [7:0] HDR       = DEF_HDR,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    input  logic        rsp_is_wr,
    input  logic        rsp_err,
    output logic [7:0]  wr_data,
    output logic        wr_req,
    input  logic        wr_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    rsp_t        rsp_q;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_req_q, wr_req_d;
    logic [15:0] frame_cnt_q;
    logic        capture, xfer, payload_end, frame_done;
`ifdef UART2APB_RSP_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign rsp_ready = (state_q == ST_IDLE);
    assign busy      = ~rsp_ready;
    assign capture   = rsp_valid & rsp_ready;
    assign xfer      = wr_req_q & wr_ready;
    assign wr_data   = wr_data_q;
    assign wr_req    = wr_req_q;
    assign frame_cnt = frame_cnt_q;

    // Next byte is prepared while the current one waits, so wr_data/wr_req
    // only move on a transfer and stay frozen under backpressure.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_req_d    = wr_req_q;
        wr_data_d   = wr_data_q;
        payload_end = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: if (rsp_valid) begin
                state_d   = ST_HDR;
                idx_d     = 2'd0;
                wr_req_d  = 1'b1;
                wr_data_d = HDR;
            end
            ST_HDR: if (xfer) begin
                state_d   = ST_STAT;
                wr_data_d = status_byte(rsp_q.is_wr, rsp_q.err);
            end
            ST_STAT: if (xfer) begin
                if (!rsp_q.is_wr) begin
                    state_d   = ST_DATA;
                    idx_d     = 2'd0;
                    wr_data_d = lane_byte(rsp_q.data, 2'd0, LSB_FIRST);
                end else begin
                    payload_end = 1'b1;
                end
            end
            ST_DATA: if (xfer) begin
                if (idx_q == 2'd3) begin
                    payload_end = 1'b1;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    wr_data_d = lane_byte(rsp_q.data, idx_q + 2'd1, LSB_FIRST);
                end
            end
`ifdef UART2APB_RSP_CHECKSUM_EN
            ST_CSUM: if (xfer) frame_done = 1'b1;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (payload_end) begin
`ifdef UART2APB_RSP_CHECKSUM_EN
            // Fold in the byte leaving this cycle; the accumulator lags by one.
            state_d   = ST_CSUM;
            wr_data_d = csum_q ^ wr_data_q;
`else
            frame_done = 1'b1;
`endif
        end

        if (frame_done) begin
            state_d  = ST_IDLE;
            wr_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            rsp_q       <= '0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= 8'h00;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_req_q  <= wr_req_d;
            wr_data_q <= wr_data_d;
            if (capture)    rsp_q       <= '{data: rsp_data, is_wr: rsp_is_wr, err: rsp_err};
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

`ifdef UART2APB_RSP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)          csum_q <= 8'h00;
        else if (capture) csum_q <= 8'h00;
        else if (xfer)    csum_q <= csum_q ^ wr_data_q;
    end
`endif

endmodule

// File: tb/tb_uart2apb_rsp_packer.sv
module tb_uart2apb_rsp_packer;
    import uart2apb_rsp_pkg::*;

    localparam logic [7:0] HDR       = 8'h5A;
    localparam bit         LSB_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_is_wr = 1'b0;
    logic        rsp_err = 1'b0;
    logic [7:0]  wr_data;
    logic        wr_req;
    logic        wr_ready = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;

    uart2apb_rsp_packer #(.HDR(HDR), .LSB_FIRST(LSB_FIRST)) dut (
        .clk(clk), .rst(rst), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_is_wr(rsp_is_wr), .rsp_err(rsp_err),
        .wr_data(wr_data), .wr_req(wr_req), .wr_ready(wr_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         lat;
    int         stable_bad;
    bit         timed_out;

    // Reference frame built straight from the frame format rules.
    task automatic build_exp(input logic [31:0] d, input bit w, input bit e, input bit append);
        logic [7:0] f[$];
        logic [7:0] cs;
        f.push_back(HDR);
        f.push_back({6'b0, w, e});
        if (!w)
            for (int i = 0; i < 4; i++)
                f.push_back(LSB_FIRST ? d[8*i +: 8] : d[8*(3-i) +: 8]);
`ifdef UART2APB_RSP_CHECKSUM_EN
        cs = 8'h00;
        foreach (f[i]) cs ^= f[i];
        f.push_back(cs);
`else
        cs = 8'h00;
`endif
        if (!append) exp_q.delete();
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -1;
        foreach (got[i]) if (got[i] !== exp_q[i]) return i;
        return -2;
    endfunction

    function automatic bit ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'b1 & $urandom_range(0, 1);
        endcase
    endfunction

    // Presents one response, then collects transferred bytes until wr_req drops.
    // lat = clocks from the capture edge until the packer is idle again.
    task automatic drive_frame(input logic [31:0] d, input bit w, input bit e,
                               input int mode, input int max_bytes);
        bit         prev_stall;
        logic [7:0] prev_data;
        bit         done;
        got.delete();
        stable_bad = 0;
        timed_out  = 1'b0;
        lat        = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        done       = 1'b0;
        @(negedge clk);
        rsp_data = d; rsp_is_wr = w; rsp_err = e; rsp_valid = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            if (max_bytes > 0 && got.size() >= max_bytes) begin
                done = 1'b1;
            end else if (!wr_req) begin
                if (prev_stall) stable_bad++;
                lat  = c + 1;
                done = 1'b1;
            end else begin
                if (prev_stall && wr_data !== prev_data) stable_bad++;
                wr_ready = ready_for(mode, c);
                if (wr_ready) got.push_back(wr_data);
                prev_stall = !wr_ready;
                prev_data  = wr_data;
            end
        end
        if (!done) timed_out = 1'b1;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_ready !== 1'b1) $display("FAIL reset_rsp_ready got=%b want=1", rsp_ready); else n_pass++;
        n_checks++; if (wr_req !== 1'b0) $display("FAIL reset_wr_req got=%b want=0", wr_req); else n_pass++;
        n_checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data got=%h want=00", wr_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (frame_cnt !== 16'h0) $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_read_basic();
        logic [15:0] c0;
        c0 = frame_cnt;
        drive_frame(32'h1234_5678, 1'b0, 1'b0, 0, 0);
        build_exp(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        n_checks++; if (first_diff() != -2) $display("FAIL read_frame got_len=%0d want_len=%0d diff_at=%0d", got.size(), exp_q.size(), first_diff()); else n_pass++;
        n_checks++; if (lat != exp_q.size() + 1) $display("FAIL read_latency got=%0d want=%0d", lat, exp_q.size() + 1); else n_pass++;
        n_checks++; if (frame_cnt !== c0 + 16'd1) $display("FAIL read_frame_cnt got=%0d want=%0d", frame_cnt, c0 + 16'd1); else n_pass++;
        n_checks++; if (rsp_ready !== 1'b1) $display("FAIL read_idle_ready got=%b want=1", rsp_ready); else n_pass++;
    endtask

    task automatic test_write_err();
        logic [31:0] d;
        d = $urandom;
        drive_frame(d, 1'b1, 1'b1, 0, 0);
        build_exp(d, 1'b1, 1'b1, 1'b0);
        n_checks++; if (first_diff() != -2) $display("FAIL write_frame got_len=%0d want_len=%0d diff_at=%0d", got.size(), exp_q.size(), first_diff()); else n_pass++;
        n_checks++; if (lat != exp_q.size() + 1) $display("FAIL write_latency got=%0d want=%0d", lat, exp_q.size() + 1); else n_pass++;
        n_checks++; if (busy !== 1'b0 || rsp_ready !== 1'b1) $display("FAIL write_idle got busy=%b ready=%b want busy=0 ready=1", busy, rsp_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        drive_frame(32'hDEAD_BEEF, 1'b0, 1'b0, 1, 0);
        build_exp(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        n_checks++; if (first_diff() != -2) $display("FAIL bp_frame got_len=%0d want_len=%0d diff_at=%0d", got.size(), exp_q.size(), first_diff()); else n_pass++;
        n_checks++; if (stable_bad != 0) $display("FAIL bp_stable got=%0d want=0 unstable stalls", stable_bad); else n_pass++;
        n_checks++; if (timed_out) $display("FAIL bp_timeout got=1 want=0"); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [15:0] c0;
        int          gap;
        bit          drop;
        a = $urandom; b = $urandom;
        c0 = frame_cnt;
        build_exp(a, 1'b0, 1'b0, 1'b0);
        build_exp(b, 1'b0, 1'b0, 1'b1);
        got.delete();
        gap = 0; drop = 1'b0;
        @(negedge clk);
        wr_ready = 1'b1;
        rsp_data = a; rsp_is_wr = 1'b0; rsp_err = 1'b0; rsp_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) rsp_data = b;
            if (drop) begin rsp_valid = 1'b0; drop = 1'b0; end
            if (c > 0 && rsp_ready && rsp_valid) drop = 1'b1;
            if (wr_req) got.push_back(wr_data);
            else if (got.size() > 0 && got.size() < exp_q.size()) gap++;
        end
        rsp_valid = 1'b0;
        n_checks++; if (first_diff() != -2) $display("FAIL b2b_frames got_len=%0d want_len=%0d diff_at=%0d", got.size(), exp_q.size(), first_diff()); else n_pass++;
        n_checks++; if (gap != 1) $display("FAIL b2b_gap got=%0d want=1 idle cycles", gap); else n_pass++;
        n_checks++; if (frame_cnt !== c0 + 16'd2) $display("FAIL b2b_frame_cnt got=%0d want=%0d", frame_cnt, c0 + 16'd2); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] c0;
        logic [31:0] d;
        bit          w, e;
        int          bad_frames, bad_stable;
        c0 = frame_cnt;
        bad_frames = 0; bad_stable = 0;
        for (int i = 0; i < 24; i++) begin
            d = $urandom; w = 1'b1 & $urandom_range(0, 1); e = 1'b1 & $urandom_range(0, 1);
            drive_frame(d, w, e, 2, 0);
            build_exp(d, w, e, 1'b0);
            n_checks++;
            if (first_diff() != -2 || timed_out) begin
                $display("FAIL rand_frame_%0d got_len=%0d want_len=%0d diff_at=%0d", i, got.size(), exp_q.size(), first_diff());
                bad_frames++;
            end else n_pass++;
            bad_stable += stable_bad;
        end
        n_checks++; if (bad_stable != 0) $display("FAIL rand_stable got=%0d want=0 unstable stalls", bad_stable); else n_pass++;
        n_checks++; if (frame_cnt !== c0 + 16'd24) $display("FAIL rand_frame_cnt got=%0d want=%0d", frame_cnt, c0 + 16'd24); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        drive_frame($urandom, 1'b0, 1'b0, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (wr_req !== 1'b0) $display("FAIL mid_rst_wr_req got=%b want=0", wr_req); else n_pass++;
        n_checks++; if (rsp_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b want=1", rsp_ready); else n_pass++;
        n_checks++; if (frame_cnt !== 16'h0) $display("FAIL mid_rst_frame_cnt got=%0d want=0", frame_cnt); else n_pass++;
        d = $urandom;
        drive_frame(d, 1'b0, 1'b0, 0, 0);
        build_exp(d, 1'b0, 1'b0, 1'b0);
        n_checks++; if (first_diff() != -2) $display("FAIL mid_rst_next_frame got_len=%0d want_len=%0d diff_at=%0d", got.size(), exp_q.size(), first_diff()); else n_pass++;
        n_checks++; if (frame_cnt !== 16'h1) $display("FAIL mid_rst_next_cnt got=%0d want=1", frame_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_err();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
